// File: rtl/file_pkg.sv
// Shared mode encoding and word decode for the file word stream receive path.
package file_pkg;

    localparam int unsigned MODE_W = 5;
    localparam int unsigned DEC_W  = 64;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_SUB = 5'd0;
    localparam mode_t MODE_INV = 5'd1;

    // Decode at a fixed wide width; callers truncate, which gives the mod 2^WIDTH wrap.
    function automatic logic [DEC_W-1:0] f_decode(
        input logic [DEC_W-1:0] data,
        input mode_t            mode,
        input logic [DEC_W-1:0] offset
    );
        logic [DEC_W-1:0] res;
        res = data;
        case (mode)
            MODE_SUB: res = data - offset;
            MODE_INV: res = ~data;
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/file_rx_fifo.sv
// First-word-fall-through FIFO with registered head word, occupancy and full/empty flags.
module file_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic                     o_not_empty,
    output logic                     o_not_full,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_not_empty;
    logic             r_not_full;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    // Next-state: pointers, level, and the word that will sit at the head after this edge.
    always_comb begin
        w_push       = i_push && r_not_full;
        w_pop        = i_pop && r_not_empty;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        w_head_nxt   = r_head;

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase

        // Head bypasses storage when the word being written becomes the head; when empty it holds.
        if (w_level_nxt != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                w_head_nxt = i_wdata;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_not_empty <= 1'b0;
            r_not_full  <= 1'b1;
            r_head      <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_not_empty <= (w_level_nxt != '0);
            r_not_full  <= (w_level_nxt != FULL_LVL);
            r_head      <= w_head_nxt;
        end
    end

    assign o_not_empty = r_not_empty;
    assign o_not_full  = r_not_full;
    assign o_head      = r_head;
    assign o_level     = r_level;

endmodule

// File: rtl/file_rx.sv
// Receive side of the file word stream: decodes mode-tagged words and buffers them for a
// valid/ready consumer, flagging words dropped while the buffer is full.
module file_rx
    import file_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [MODE_W-1:0]      in_mode,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    logic [WIDTH-1:0] w_dec_data;
    logic             w_not_empty;
    logic             w_not_full;
    logic             r_overflow;

    assign w_dec_data = WIDTH'(f_decode(DEC_W'(in_data), in_mode, DEC_W'(OFFSET)));

    file_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (in_valid),
        .i_wdata     (w_dec_data),
        .i_pop       (out_ready),
        .o_not_empty (w_not_empty),
        .o_not_full  (w_not_full),
        .o_head      (out_data),
        .o_level     (level)
    );

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !w_not_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign in_ready  = w_not_full;
    assign out_valid = w_not_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_file_rx.sv
// Scoreboard bench for file_rx: directed scenarios followed by randomized traffic.
module tb_file_rx;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned OFFSET = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [4:0] in_mode;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;

    int         errors = 0;
    int         checks = 0;

    logic [7:0] exp_q[$];
    int         mcount   = 0;
    bit         movf     = 1'b0;
    logic [7:0] mon_last = 8'h00;
    bit         chk_en   = 1'b0;
    int         bias     = 5;

    always #5 clk = ~clk;

    file_rx #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .OFFSET (OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_decode(input int d, input int m);
        int off;
        int r;
        off = int'(OFFSET % 256);
        if (m == 0)      r = (d + 256 - off) % 256;
        else if (m == 1) r = 255 - d;
        else             r = d;
        return 8'(r);
    endfunction

    // Drive one cycle of inputs, then update the reference model for that edge.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input logic [4:0] m,
                         input bit o);
        bit acc;
        bit pop;
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = o;
        @(posedge clk);
        if (r) begin
            mcount   = 0;
            movf     = 1'b0;
            exp_q.delete();
            mon_last = 8'h00;
            chk_en   = 1'b1;
        end else begin
            acc = v && (mcount < int'(DEPTH));
            pop = o && (mcount > 0);
            if (v && !acc) movf = 1'b1;
            if (acc) exp_q.push_back(model_decode(int'(d), int'(m)));
            mcount = mcount + int'(acc) - int'(pop);
        end
        #1;
    endtask

    // Monitor: mid-cycle status checks, head-word compare, pop on handshake.
    always @(negedge clk) begin
        if (chk_en) begin
            check("level", 32'(level), 32'(mcount));
            check("out_valid", 32'(out_valid), 32'(mcount != 0));
            check("in_ready", 32'(in_ready), 32'(mcount != int'(DEPTH)));
            check("overflow", 32'(overflow), 32'(movf));
            if (exp_q.size() != 0) begin
                check("out_data_head", 32'(out_data), 32'(exp_q[0]));
                if (out_valid && out_ready && !rst) mon_last = exp_q.pop_front();
            end else begin
                check("out_data_hold", 32'(out_data), 32'(mon_last));
            end
        end
    end

    initial begin
        cycle(1'b1, 1'b0, 8'h00, 5'd0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 5'd0, 1'b0);

        // Decode cases while filling, then a dropped word and a drain past empty.
        cycle(1'b0, 1'b1, 8'h05, 5'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 5'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'hA5, 5'd1, 1'b0);
        cycle(1'b0, 1'b1, 8'h3C, 5'd7, 1'b0);
        cycle(1'b0, 1'b1, 8'h99, 5'd2, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);

        // Fill 1..4 with a fifth dropped, then drain in order.
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(i), 5'd2, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);

        // Steady push+pop at level 2 across pointer wrap.
        cycle(1'b0, 1'b1, 8'h10, 5'd3, 1'b0);
        cycle(1'b0, 1'b1, 8'h11, 5'd3, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 5'd4, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);

        // Full with push+pop in the same cycle: pop only, level drops to 3.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 5'd0, 1'b0);
        cycle(1'b0, 1'b1, 8'h77, 5'd1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

        // Reset with words stored and overflow set.
        cycle(1'b1, 1'b1, 8'h55, 5'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) bias = int'($urandom_range(1, 9));
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) != 0,
                  8'($urandom),
                  5'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 2)),
                  int'($urandom_range(0, 9)) < bias);
        end

        repeat (6) cycle(1'b0, 1'b0, 8'h00, 5'd0, 1'b1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
